seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter CLK_HZ, 100_000_000: clk frequency; one countdown second equals CLK_HZ cycles.
REQ-002 Parameter DIGITS, 4: number of multiplexed digits; legal range 2..8.
REQ-003 Parameter SCAN_DIV, 100_000: clk cycles per digit dwell.
REQ-004 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port state, input, 4: FSM state code; S4_DISPLAY=4, S5_COMPUTE=5, S6_ERROR=6, S9_WAIT=9.
REQ-007 Port op_type, input, 4: confirmed operation, one-hot; 0001 T, 0010 A, 0100 B, 1000 C.
REQ-008 Port wait_sec, input, 7: countdown start value in seconds, sampled on S9_WAIT entry.
REQ-009 Port seg, output, 7: segments {a,b,c,d,e,f,g}, active-high, registered.
REQ-010 Port an, output, DIGITS: digit enable, one-hot, active-high, registered.
REQ-011 Port timeout, output, 1: one-cycle pulse when the countdown reaches 0.
REQ-012 Port cnt_val, output, 7: current countdown value, registered.

Function
REQ-013 Entry into S9_WAIT SHALL be detected as state==9 while the registered previous state !=9.
- On the entry edge: sec_cnt loads min(wait_sec, 99) and the prescaler clears.
REQ-014 In S9_WAIT, the prescaler SHALL count 0..CLK_HZ-1 and wrap.
- On each wrap, sec_cnt decrements if nonzero; it holds at 0.
REQ-015 timeout SHALL be high for exactly one cycle, in the cycle after sec_cnt becomes 0.
- This applies to both a 1->0 decrement and a load of 0.
- At most one pulse per S9_WAIT visit.
REQ-016 Outside S9_WAIT: prescaler=0, sec_cnt=0, timeout=0.
- Leaving S9_WAIT mid-count abandons the count.
- Re-entry reloads from wait_sec.
REQ-017 The scan counter SHALL count 0..SCAN_DIV-1 continuously in every state.
- On wrap, digit index advances 0->DIGITS-1->0.
- an is the one-hot of the index.
REQ-018 seg and an SHALL update on the same edge, one cycle after the index changes; an never has zero or multiple bits set after reset.
REQ-019 Digit codes: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000.
REQ-020 Letter codes: T=0000111, A=1110111, B=0011111, C=1001110, E=1001111, dash=0000001.
REQ-021 S9_WAIT display:
- digit0 = sec_cnt ones.
- digit1 = sec_cnt tens, blanked when tens==0.
- Digits 2 and above are blank.
REQ-022 S4_DISPLAY and S5_COMPUTE display:
- digit0 = letter for op_type; a non-one-hot op_type shows dash.
- Other digits are blank.
REQ-023 S6_ERROR display: digit0 = E, other digits blank.
- All other states: every digit blank.
REQ-024 cnt_val SHALL equal sec_cnt.

Reset
REQ-025 rst high SHALL asynchronously force:
- seg=0000000, an=one-hot bit0, timeout=0, cnt_val=0.
- Prescaler, scan counter and digit index = 0.
- Previous-state register = 0.
REQ-026 After rst deasserts with state already 9, the first edge SHALL be treated as S9_WAIT entry.
- Reset mid-countdown discards the count.

Configuration
REQ-027 Macro SEG_BLINK_EN, when defined, SHALL add a 2 Hz blink (CLK_HZ/4 cycles on, CLK_HZ/4 off).
- Blink applies in S6_ERROR and in S9_WAIT while sec_cnt<=3.
- Off phase: seg=0000000 while an continues scanning.
- Blink phase restarts "on" at every state change.
REQ-028 Without SEG_BLINK_EN, no blink counter SHALL exist and all displays are steady.

Verification
REQ-029 Bench parameters: CLK_HZ=20, SCAN_DIV=4, DIGITS=4.
REQ-030 Scenario, S9 countdown:
- Stimulus: wait_sec=12, enter S9.
- Response: cnt_val=12 after 1 edge, 11 after 20 more, reaches 0 at 240 cycles.
- timeout pulses once, 1 cycle later; digit1 shows 1 then blank from 9 down.
REQ-031 Scenario, clamp and zero load:
- wait_sec=120 -> cnt_val=99.
- wait_sec=0 -> cnt_val=0 and timeout high for exactly 1 cycle, 2 edges after entry.
REQ-032 Scenario, scan timing:
- Stimulus: state=5, op_type=0100.
- Response: an walks 0001->0010->0100->1000->0001 every 4 cycles; seg=0011111 only when an=0001.
- op_type=0011 -> 0000001.
REQ-033 Scenario, abort and reset:
- Leave S9 at cnt_val=7 -> cnt_val=0, no timeout.
- Re-enter with wait_sec=3 -> reload to 3.
- Assert rst mid-scan -> an=0001, seg=0 immediately, without waiting for a clock edge.
REQ-034 Scenario, blink (SEG_BLINK_EN defined):
- state=6 -> seg alternates 1001111/0000000 on digit0 every 5 cycles.
- Without the macro -> steady 1001111.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed 7-segment driver with a seconds countdown for the wait state.
//   The digit scan runs continuously; what each digit shows depends on the
//   incoming FSM state code (wait countdown, operation letter, error letter).
//
// Parameters
//   CLK_HZ   clk cycles per countdown second
//   DIGITS   number of multiplexed digits (2..8)
//   SCAN_DIV clk cycles each digit stays enabled
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   state    FSM state code (4 display, 5 compute, 6 error, 9 wait)
//   op_type  one-hot operation: 0001 T, 0010 A, 0100 B, 1000 C
//   wait_sec countdown start, sampled when the wait state is entered
//   seg      registered segments {a,b,c,d,e,f,g}, active-high
//   an       registered one-hot digit enable, active-high
//   timeout  one-cycle pulse once the countdown has reached zero
//   cnt_val  current countdown value
//
// Build option
//   SEG_BLINK_EN  adds a 2 Hz blink of the segments in the error state and in
//                 the last three seconds of the countdown.

module seg_scan_display #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        state,
  input  logic [3:0]        op_type,
  input  logic [6:0]        wait_sec,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              timeout,
  output logic [6:0]        cnt_val
);

  typedef enum logic [3:0] {
    S4_DISPLAY = 4'd4,
    S5_COMPUTE = 4'd5,
    S6_ERROR   = 4'd6,
    S9_WAIT    = 4'd9
  } state_e;

  localparam int unsigned PR_W  = $clog2(CLK_HZ + 1);
  localparam int unsigned SC_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam logic [DIGITS-1:0] AN_FIRST = {{(DIGITS-1){1'b0}}, 1'b1};

  function automatic logic [6:0] digit_code(input logic [6:0] d);
    logic [6:0] code;
    case (d)
      7'd0:    code = 7'b1111110;
      7'd1:    code = 7'b0110000;
      7'd2:    code = 7'b1101101;
      7'd3:    code = 7'b1111001;
      7'd4:    code = 7'b0110011;
      7'd5:    code = 7'b1011011;
      7'd6:    code = 7'b1011111;
      7'd7:    code = 7'b1110000;
      7'd8:    code = 7'b1111111;
      7'd9:    code = 7'b1111011;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] letter_code(input logic [3:0] op);
    logic [6:0] code;
    case (op)
      4'b0001: code = SEG_T;
      4'b0010: code = SEG_A;
      4'b0100: code = SEG_B;
      4'b1000: code = SEG_C;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

  // registered state
  logic [3:0]       prev_state;
  logic [PR_W-1:0]  presc;
  logic [6:0]       sec_cnt;
  logic             fired;
  logic [SC_W-1:0]  scan_cnt;
  logic [IDX_W-1:0] digit_idx;

  // next-state values
  logic             in_wait;
  logic             wait_entry;
  logic             presc_wrap;
  logic [PR_W-1:0]  presc_nxt;
  logic [6:0]       sec_nxt;
  logic             fired_nxt;
  logic             timeout_nxt;
  logic             scan_wrap;
  logic [SC_W-1:0]  scan_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [6:0]       tens;
  logic [6:0]       ones;
  logic [6:0]       seg_nxt;
  logic [DIGITS-1:0] an_nxt;

`ifdef SEG_BLINK_EN
  localparam int unsigned BL_W = $clog2(CLK_HZ / 2 + 1);
  logic [BL_W-1:0] blink_cnt;
  logic [BL_W-1:0] blink_base;
  logic [BL_W-1:0] blink_nxt;
  logic            blink_off;
  logic            blink_zone;
`endif

  assign cnt_val = sec_cnt;

  // countdown
  always_comb begin
    in_wait     = (state == S9_WAIT);
    wait_entry  = in_wait && (prev_state != S9_WAIT);
    presc_wrap  = (presc == PR_W'(CLK_HZ - 1));
    presc_nxt   = '0;
    sec_nxt     = '0;
    fired_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    if (wait_entry) begin
      sec_nxt = (wait_sec > 7'd99) ? 7'd99 : wait_sec;
    end else if (in_wait) begin
      presc_nxt = presc_wrap ? '0 : presc + 1'b1;
      sec_nxt   = (presc_wrap && (sec_cnt != 7'd0)) ? sec_cnt - 7'd1 : sec_cnt;
      fired_nxt = fired;
      // Pulse follows the cycle in which sec_cnt already reads zero, so a
      // load of zero and a 1->0 decrement both pulse one edge later.
      if ((sec_cnt == 7'd0) && !fired) begin
        timeout_nxt = 1'b1;
        fired_nxt   = 1'b1;
      end
    end
  end

  // digit scan and segment selection
  always_comb begin
    scan_wrap = (scan_cnt == SC_W'(SCAN_DIV - 1));
    scan_nxt  = scan_wrap ? '0 : scan_cnt + 1'b1;
    idx_nxt   = digit_idx;
    if (scan_wrap) begin
      idx_nxt = (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end

    tens = sec_cnt / 7'd10;
    ones = sec_cnt - tens * 7'd10;

    seg_nxt = SEG_BLANK;
    case (state)
      S9_WAIT: begin
        if (digit_idx == '0) begin
          seg_nxt = digit_code(ones);
        end else if ((digit_idx == IDX_W'(1)) && (tens != 7'd0)) begin
          seg_nxt = digit_code(tens);
        end
      end
      S4_DISPLAY, S5_COMPUTE: begin
        if (digit_idx == '0) seg_nxt = letter_code(op_type);
      end
      S6_ERROR: begin
        if (digit_idx == '0) seg_nxt = SEG_E;
      end
      default: seg_nxt = SEG_BLANK;
    endcase

`ifdef SEG_BLINK_EN
    // A state change restarts the blink in its "on" half on that same edge.
    blink_base = (state != prev_state) ? '0 : blink_cnt;
    blink_nxt  = (blink_base == BL_W'(CLK_HZ / 2 - 1)) ? '0 : blink_base + 1'b1;
    blink_off  = (blink_base >= BL_W'(CLK_HZ / 4));
    blink_zone = (state == S6_ERROR) || (in_wait && (sec_cnt <= 7'd3));
    if (blink_zone && blink_off) seg_nxt = SEG_BLANK;
`endif

    an_nxt = AN_FIRST << digit_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= '0;
      presc      <= '0;
      sec_cnt    <= '0;
      fired      <= 1'b0;
      timeout    <= 1'b0;
      scan_cnt   <= '0;
      digit_idx  <= '0;
      seg        <= SEG_BLANK;
      an         <= AN_FIRST;
    end else begin
      prev_state <= state;
      presc      <= presc_nxt;
      sec_cnt    <= sec_nxt;
      fired      <= fired_nxt;
      timeout    <= timeout_nxt;
      scan_cnt   <= scan_nxt;
      digit_idx  <= idx_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
    end
  end

`ifdef SEG_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  localparam int CLK_HZ   = 20;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        state;
  logic [3:0]        op_type;
  logic [6:0]        wait_sec;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              timeout;
  logic [6:0]        cnt_val;

  int checks = 0;
  int errors = 0;

  // reference model bookkeeping
  int k;              // edges since reset release
  int j;              // edges since wait-state entry (0 = not in a visit)
  int L;              // loaded countdown value of the current visit
  int b;              // edges since the last state change
  logic [3:0] prev_st;
  logic [6:0]        exp_seg;
  logic [DIGITS-1:0] exp_an;
  logic              exp_to;
  logic [6:0]        exp_cnt;

  seg_scan_display #(
    .CLK_HZ  (CLK_HZ),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .op_type (op_type),
    .wait_sec(wait_sec),
    .seg     (seg),
    .an      (an),
    .timeout (timeout),
    .cnt_val (cnt_val)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] seg_ref(input logic [3:0] st, input logic [3:0] op,
                                         input int sec, input int idx);
    logic [6:0] r;
    r = 7'b0000000;
    if (st == 4'd9) begin
      if (idx == 0) r = digit_seg(sec % 10);
      else if (idx == 1 && (sec / 10) != 0) r = digit_seg(sec / 10);
    end else if (st == 4'd4 || st == 4'd5) begin
      if (idx == 0) begin
        case (op)
          4'b0001: r = 7'b0000111;
          4'b0010: r = 7'b1110111;
          4'b0100: r = 7'b0011111;
          4'b1000: r = 7'b1001110;
          default: r = 7'b0000001;
        endcase
      end
    end else if (st == 4'd6 && idx == 0) begin
      r = 7'b1001111;
    end
    return r;
  endfunction

  function automatic int model_sec();
    int v;
    if (j == 0) return 0;
    v = L - (j - 1) / CLK_HZ;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_reset();
    k = 0; j = 0; L = 0; b = -1; prev_st = 4'd0;
  endtask

  // Advance one clock edge and compute what the outputs must be after it.
  task automatic advance();
    int idx_b;
    int sec_b;
    idx_b = (k / SCAN_DIV) % DIGITS;
    sec_b = model_sec();
    @(posedge clk);
    k++;
    if (state == 4'd9) begin
      if (prev_st != 4'd9) begin
        j = 1;
        L = (wait_sec > 7'd99) ? 99 : int'(wait_sec);
      end else begin
        j++;
      end
    end else begin
      j = 0;
    end
    if (state != prev_st) b = 0; else b++;
    prev_st = state;
    exp_seg = seg_ref(state, op_type, sec_b, idx_b);
`ifdef SEG_BLINK_EN
    if ((state == 4'd6 || (state == 4'd9 && sec_b <= 3)) && (b % (CLK_HZ / 2)) >= CLK_HZ / 4)
      exp_seg = 7'b0000000;
`endif
    exp_an  = DIGITS'(1) << idx_b;
    exp_cnt = 7'(model_sec());
    exp_to  = (j != 0) && (j == L * CLK_HZ + 2);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 4'd0; op_type = 4'd0; wait_sec = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({seg, an, timeout, cnt_val} !== {7'b0, 4'b0001, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL reset_state: seg=%b an=%b to=%b cnt=%0d required seg=0000000 an=0001 to=0 cnt=0",
               seg, an, timeout, cnt_val);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_countdown();
    int pulses;
    pulses = 0;
    state = 4'd0; wait_sec = 7'd12;
    repeat (3) begin
      advance();
      checks++;
      if ({seg, an, timeout, cnt_val} !== {exp_seg, exp_an, exp_to, exp_cnt}) begin
        errors++;
        $display("FAIL cd_idle: seg=%b an=%b to=%b cnt=%0d required %b %b %b %0d",
                 seg, an, timeout, cnt_val, exp_seg, exp_an, exp_to, exp_cnt);
      end
    end
    state = 4'd9;
    for (int n = 1; n <= 270; n++) begin
      advance();
      if (timeout) pulses++;
      checks++;
      if ({seg, an, timeout, cnt_val} !== {exp_seg, exp_an, exp_to, exp_cnt}) begin
        errors++;
        $display("FAIL cd_edge%0d: seg=%b an=%b to=%b cnt=%0d required %b %b %b %0d",
                 n, seg, an, timeout, cnt_val, exp_seg, exp_an, exp_to, exp_cnt);
      end
      if (n == 1 || n == 21 || n == 240 || n == 241 || n == 242) begin
        checks++;
        if (cnt_val !== ((n == 1) ? 7'd12 : (n == 21) ? 7'd11 : (n == 240) ? 7'd1 : 7'd0) ||
            timeout !== (n == 242)) begin
          errors++;
          $display("FAIL cd_milestone%0d: cnt=%0d to=%b", n, cnt_val, timeout);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL cd_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_clamp_zero();
    int pulses;
    state = 4'd0;
    repeat (2) advance();
    wait_sec = 7'd120; state = 4'd9;
    advance();
    checks++;
    if (cnt_val !== 7'd99) begin
      errors++;
      $display("FAIL clamp: cnt=%0d required 99", cnt_val);
    end
    repeat (5) advance();
    state = 4'd0;
    repeat (2) advance();
    wait_sec = 7'd0; state = 4'd9;
    pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      advance();
      if (timeout) pulses++;
      checks++;
      if ({seg, an, timeout, cnt_val} !== {exp_seg, exp_an, exp_to, exp_cnt} || timeout !== (n == 2)) begin
        errors++;
        $display("FAIL zero_edge%0d: seg=%b an=%b to=%b cnt=%0d required %b %b %b %0d",
                 n, seg, an, timeout, cnt_val, exp_seg, exp_an, (n == 2), exp_cnt);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL zero_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_scan();
    state = 4'd5; op_type = 4'b0100;
    for (int n = 1; n <= 40; n++) begin
      advance();
      checks++;
      if ({seg, an} !== {exp_seg, exp_an} || seg !== ((an == 4'b0001) ? 7'b0011111 : 7'b0)) begin
        errors++;
        $display("FAIL scan_B%0d: seg=%b an=%b required %b %b", n, seg, an, exp_seg, exp_an);
      end
    end
    op_type = 4'b0011;
    for (int n = 1; n <= 16; n++) begin
      advance();
      checks++;
      if ({seg, an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL scan_dash%0d: seg=%b an=%b required %b %b", n, seg, an, exp_seg, exp_an);
      end
    end
    for (int n = 1; n <= 80; n++) begin
      if ((n % 5) == 1) begin
        state = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'd5;
        if ($urandom_range(0, 1) == 0) op_type = 4'b0001 << $urandom_range(0, 3);
        else op_type = 4'($urandom);
      end
      advance();
      checks++;
      if ({seg, an, timeout, cnt_val} !== {exp_seg, exp_an, exp_to, exp_cnt}) begin
        errors++;
        $display("FAIL scan_rand%0d: seg=%b an=%b op=%b required %b %b",
                 n, seg, an, op_type, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_abort_reset();
    int guard;
    state = 4'd0;
    advance();
    wait_sec = 7'd9; state = 4'd9;
    guard = 0;
    do begin
      advance();
      guard++;
      checks++;
      if ({seg, an, timeout, cnt_val} !== {exp_seg, exp_an, exp_to, exp_cnt}) begin
        errors++;
        $display("FAIL abort_run: seg=%b an=%b to=%b cnt=%0d required %b %b %b %0d",
                 seg, an, timeout, cnt_val, exp_seg, exp_an, exp_to, exp_cnt);
      end
    end while (cnt_val !== 7'd7 && guard < 400);
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL abort_reach7: cnt=%0d never reached 7", cnt_val);
    end
    state = 4'd0;
    for (int n = 1; n <= 25; n++) begin
      advance();
      checks++;
      if (cnt_val !== 7'd0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL abort_left%0d: cnt=%0d to=%b required 0 0", n, cnt_val, timeout);
      end
    end
    wait_sec = 7'd3; state = 4'd9;
    advance();
    checks++;
    if (cnt_val !== 7'd3) begin
      errors++;
      $display("FAIL reload: cnt=%0d required 3", cnt_val);
    end
    guard = 0;
    do begin
      advance();
      guard++;
    end while ((exp_an == 4'b0001 || an == 4'b0001) && guard < 20);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({seg, an, timeout, cnt_val} !== {7'b0, 4'b0001, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL async_reset: seg=%b an=%b to=%b cnt=%0d required 0000000 0001 0 0",
               seg, an, timeout, cnt_val);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    advance();
    checks++;
    if (cnt_val !== 7'd3) begin
      errors++;
      $display("FAIL reset_reentry: cnt=%0d required 3", cnt_val);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 7))
        0: state = 4'd0;
        1: state = 4'd4;
        2: state = 4'd5;
        3: state = 4'd6;
        7: state = 4'($urandom);
        default: state = 4'd9;
      endcase
      op_type  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      wait_sec = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 4));
      hold = $urandom_range(1, 120);
      for (int n = 0; n < hold; n++) begin
        advance();
        checks++;
        if ({seg, an, timeout, cnt_val} !== {exp_seg, exp_an, exp_to, exp_cnt}) begin
          errors++;
          $display("FAIL rand_seg%0d: st=%0d seg=%b an=%b to=%b cnt=%0d required %b %b %b %0d",
                   s, state, seg, an, timeout, cnt_val, exp_seg, exp_an, exp_to, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_blink();
    state = 4'd0;
    advance();
    state = 4'd6;
    for (int n = 1; n <= 40; n++) begin
      advance();
      checks++;
      if ({seg, an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL blink%0d: seg=%b an=%b required %b %b", n, seg, an, exp_seg, exp_an);
      end
`ifndef SEG_BLINK_EN
      if (an == 4'b0001) begin
        checks++;
        if (seg !== 7'b1001111) begin
          errors++;
          $display("FAIL steady_E%0d: seg=%b required 1001111", n, seg);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_clamp_zero();
    test_scan();
    test_abort_reset();
    test_random();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
